// File: rtl/spi_slave.sv
// SPI slave front end: deserialises 10-bit command words from MOSI and
// returns one read-data byte on MISO for read-data commands.
module spi_slave #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);

  // state     | meaning
  // IDLE      | waiting for SS_n low
  // CHK_CMD   | sampling bit 9, choosing the frame path
  // WRITE     | collecting a write-address / write-data word
  // READ_ADD  | collecting a read-address word
  // READ_DATA | collecting a read-data word, then returning one byte

  localparam int CW = ADDR_SIZE + 2;
  localparam int BW = $clog2(CW + 1);
  localparam int TW = $clog2(ADDR_SIZE);
  localparam logic [BW-1:0] CNT_LAST = BW'(CW - 1);
  localparam logic [BW-1:0] CNT_FULL = BW'(CW);
  localparam logic [TW-1:0] TX_LAST  = TW'(ADDR_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t                 state, next_state;
  logic                   rd_addr_ok;
  logic [BW-1:0]          bit_cnt;
  // Holds the bits already received; the final bit is taken straight from MOSI.
  logic [CW-2:0]          rx_shift;
  logic [ADDR_SIZE-1:0]   tx_shift;
  logic [TW-1:0]          tx_cnt;
  logic                   tx_busy;
  logic                   tx_sent;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (SS_n) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = CHK_CMD;
        CHK_CMD: begin
          if (!MOSI)          next_state = WRITE;
          else if (rd_addr_ok) next_state = READ_DATA;
          else                next_state = READ_ADD;
        end
        default: next_state = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_shift   <= '0;
      bit_cnt    <= '0;
      rd_addr_ok <= 1'b0;
      tx_shift   <= '0;
      tx_cnt     <= '0;
      tx_busy    <= 1'b0;
      tx_sent    <= 1'b0;
      MISO       <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n) begin
        bit_cnt <= '0;
        tx_cnt  <= '0;
        tx_busy <= 1'b0;
        tx_sent <= 1'b0;
        MISO    <= 1'b0;
      end else begin
        case (state)
          CHK_CMD: begin
            rx_shift <= {rx_shift[CW-3:0], MOSI};
            bit_cnt  <= BW'(1);
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (bit_cnt < CNT_FULL) begin
              rx_shift <= {rx_shift[CW-3:0], MOSI};
              bit_cnt  <= bit_cnt + BW'(1);
              if (bit_cnt == CNT_LAST) begin
                rx_data  <= {rx_shift, MOSI};
                rx_valid <= 1'b1;
                if (state == READ_ADD)  rd_addr_ok <= 1'b1;
                if (state == READ_DATA) rd_addr_ok <= 1'b0;
              end
            end
            // One response byte per frame, only once the command word is out.
            if (state == READ_DATA) begin
              if (tx_busy) begin
                if (tx_cnt != '0) begin
                  MISO     <= tx_shift[ADDR_SIZE-1];
                  tx_shift <= {tx_shift[ADDR_SIZE-2:0], 1'b0};
                  tx_cnt   <= tx_cnt - TW'(1);
                end else begin
                  MISO    <= 1'b0;
                  tx_busy <= 1'b0;
                end
              end else if (bit_cnt == CNT_FULL && !tx_sent && tx_valid) begin
                MISO     <= tx_data[ADDR_SIZE-1];
                tx_shift <= {tx_data[ADDR_SIZE-2:0], 1'b0};
                tx_cnt   <= TX_LAST;
                tx_busy  <= 1'b1;
                tx_sent  <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: frames driven from tasks, received words
// checked against a scoreboard queue, MISO checked bit by bit.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ss_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] mem_byte = 8'h00;
  logic       tx_en = 1'b0;
  logic       tx_force = 1'b0;
  logic       tx_valid;

  int         checks = 0;
  int         errors = 0;
  int         rx_cnt = 0;
  int         cnt0;
  logic [9:0] sb_q[$];
  logic       prev_valid = 1'b0;
  logic [9:0] w6;

  always #5 clk = ~clk;

  // Memory model: answers a read-data command combinationally from rx_data.
  assign tx_valid = (tx_en & rx_valid & (rx_data[9:8] == 2'b11)) | tx_force;

  spi_slave #(.ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (ss_n),
    .MOSI     (mosi),
    .MISO     (miso),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (mem_byte),
    .tx_valid (tx_valid)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (rx_valid) begin
        rx_cnt++;
        chk("rx_b2b", {15'b0, prev_valid}, 16'h0);
        if (sb_q.size() == 0) chk("rx_spurious", {15'b0, rx_valid}, 16'h0);
        else                  chk("rx_data", {6'b0, rx_data}, {6'b0, sb_q.pop_front()});
      end
      prev_valid = rx_valid;
    end
  end

  // Drives one frame starting from IDLE; nbits < 10 aborts with SS_n high.
  task automatic frame(input logic [9:0] w, input int nbits, input bit exp_tx,
                       input logic [7:0] exp_byte);
    logic e;
    if (nbits == 10) sb_q.push_back(w);
    @(negedge clk);
    ss_n = 1'b0;
    mosi = 1'($urandom);
    for (int i = 9; i > 9 - nbits; i--) begin
      @(negedge clk);
      mosi = w[i];
    end
    if (nbits == 10) begin
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        e = (exp_tx && c >= 1 && c <= 8) ? exp_byte[8-c] : 1'b0;
        chk("miso", {15'b0, miso}, {15'b0, e});
        mosi = 1'($urandom);
      end
    end else begin
      @(negedge clk);
    end
    ss_n = 1'b1;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_miso", {15'b0, miso}, 16'h0);
    chk("rst_rxv", {15'b0, rx_valid}, 16'h0);
    chk("rst_rxd", {6'b0, rx_data}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    frame(10'h0A5, 10, 1'b0, 8'h00);
    chk("wa_rdok", {15'b0, dut.rd_addr_ok}, 16'h0);

    frame(10'h210, 10, 1'b0, 8'h00);
    chk("ra_rdok", {15'b0, dut.rd_addr_ok}, 16'h1);

    mem_byte = 8'hC3;
    tx_en    = 1'b1;
    frame(10'h300, 10, 1'b1, 8'hC3);
    tx_en    = 1'b0;
    chk("rd_rdok", {15'b0, dut.rd_addr_ok}, 16'h0);

    // Leading 1 without a fresh address takes the read-address path; tx_valid ignored.
    tx_force = 1'b1;
    frame(10'h2FF, 10, 1'b0, 8'h00);
    tx_force = 1'b0;
    chk("rd2_rdok", {15'b0, dut.rd_addr_ok}, 16'h1);

    frame(10'h155, 10, 1'b0, 8'h00);

    cnt0 = rx_cnt;
    w6   = 10'h1A0;
    frame(w6, 6, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    chk("abort_nv", 16'(rx_cnt), 16'(cnt0));
    chk("abort_rxd", {6'b0, rx_data}, 16'h155);
    chk("abort_rdok", {15'b0, dut.rd_addr_ok}, 16'h1);
    frame(10'h1FF, 10, 1'b0, 8'h00);

    // Read-data frame interrupted by reset at E14.
    mem_byte = 8'h5A;
    tx_en    = 1'b1;
    sb_q.push_back(10'h3AA);
    @(negedge clk);
    ss_n = 1'b0;
    for (int i = 9; i >= 0; i--) begin
      @(negedge clk);
      mosi = w6[0] ^ 1'b0 ^ (10'h3AA >> i) & 1'b1;
    end
    @(negedge clk);
    chk("rst6_c0", {15'b0, miso}, 16'h0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("rst6_bit", {15'b0, miso}, {15'b0, mem_byte[8-c]});
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst6_miso", {15'b0, miso}, 16'h0);
    chk("rst6_rdok", {15'b0, dut.rd_addr_ok}, 16'h0);
    chk("rst6_rxd", {6'b0, rx_data}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ss_n  = 1'b1;
    tx_en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("rst6_quiet", {15'b0, miso}, 16'h0);
    end

    tx_force = 1'b1;
    frame(10'h2AB, 10, 1'b0, 8'h00);
    tx_force = 1'b0;
    chk("post_rst_rdok", {15'b0, dut.rd_addr_ok}, 16'h1);

    // Read-data with no memory response: MISO stays low.
    frame(10'h3C0, 10, 1'b0, 8'h00);
    chk("norsp_rdok", {15'b0, dut.rd_addr_ok}, 16'h0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 16'(sb_q.size()), 16'h0);
    chk("rx_total", 16'(rx_cnt), 16'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
